// File: rtl/cam_rx_capture_if.sv
// Camera bus and qualified pixel stream bundle for cam_rx_capture.
// The slave side is the capture block; the master side is the sensor/consumer.
interface cam_rx_capture_if #(
    parameter int PIXEL_WIDTH = 8,
    parameter int HCNT_WIDTH  = 10,
    parameter int VCNT_WIDTH  = 9
);
    logic                   enable;
    logic                   fval;
    logic                   lval;
    logic                   dval;
    logic [PIXEL_WIDTH-1:0] data_l;
    logic [PIXEL_WIDTH-1:0] data_r;
    logic                   err_clr;

    logic                   pix_valid;
    logic                   pix_sof;
    logic [HCNT_WIDTH-1:0]  pix_x;
    logic [VCNT_WIDTH-1:0]  pix_y;
    logic [PIXEL_WIDTH-1:0] pix_data_l;
    logic [PIXEL_WIDTH-1:0] pix_data_r;
    logic                   line_end;
    logic                   frame_end;
    logic [HCNT_WIDTH-1:0]  line_len;
    logic [VCNT_WIDTH-1:0]  line_cnt;
    logic [15:0]            frame_cnt;
    logic                   err_hlen;
    logic                   err_vlen;

    modport master (
        output enable, fval, lval, dval, data_l, data_r, err_clr,
        input  pix_valid, pix_sof, pix_x, pix_y, pix_data_l, pix_data_r,
        input  line_end, frame_end, line_len, line_cnt, frame_cnt, err_hlen, err_vlen
    );

    modport slave (
        input  enable, fval, lval, dval, data_l, data_r, err_clr,
        output pix_valid, pix_sof, pix_x, pix_y, pix_data_l, pix_data_r,
        output line_end, frame_end, line_len, line_cnt, frame_cnt, err_hlen, err_vlen
    );
endinterface

// File: rtl/cam_rx_capture.sv
// Camera front end: registers the raw parallel bus, qualifies pixels with X/Y
// coordinates, and measures line/frame geometry against the expected active size.
module cam_rx_capture #(
    parameter int PIXEL_WIDTH = 8,
    parameter int HCNT_WIDTH  = 10,
    parameter int VCNT_WIDTH  = 9,
    parameter int HACT        = 320,
    parameter int VACT        = 480
) (
    input  logic               clk,
    input  logic               rst,
    cam_rx_capture_if.slave    bus
);
    localparam logic [1:0] ST_SYNC  = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_SKIP  = 2'd2;
    localparam logic [1:0] ST_FRAME = 2'd3;

    localparam logic [HCNT_WIDTH-1:0] HACT_C = HCNT_WIDTH'(HACT);
    localparam logic [VCNT_WIDTH-1:0] VACT_C = VCNT_WIDTH'(VACT);
    localparam logic [HCNT_WIDTH-1:0] X_MAX  = {HCNT_WIDTH{1'b1}};
    localparam logic [VCNT_WIDTH-1:0] Y_MAX  = {VCNT_WIDTH{1'b1}};
    localparam logic [HCNT_WIDTH-1:0] X_ONE  = HCNT_WIDTH'(1);
    localparam logic [VCNT_WIDTH-1:0] Y_ONE  = VCNT_WIDTH'(1);

    logic                   s1_vld_r;
    logic                   s1_en_r, s1_fval_r, s1_lval_r, s1_dval_r, s1_clr_r;
    logic [PIXEL_WIDTH-1:0] s1_dl_r, s1_dr_r;
    logic                   s2_fval_r, s2_lval_r;

    logic [1:0]             state_r;
    logic [HCNT_WIDTH-1:0]  x_cnt_r;
    logic [VCNT_WIDTH-1:0]  y_cnt_r;
    logic                   has_pix_r, sof_done_r;

    logic [1:0]             state_nxt_s;
    logic [HCNT_WIDTH-1:0]  x_nxt_s, x_base_s;
    logic [VCNT_WIDTH-1:0]  y_nxt_s, y_line_s;
    logic                   has_pix_nxt_s, sof_done_nxt_s, capture_s;
    logic                   pix_s, pix_ok_s, sof_s, le_s, herr_s, fe_s, verr_s;
    logic                   fval_rise_s, fval_fall_s, lval_rise_s, lval_fall_s;

    logic                   st1_valid_r, st1_sof_r, st1_le_r, st1_herr_r;
    logic                   st1_fe_r, st1_verr_r, st1_clr_r;
    logic [HCNT_WIDTH-1:0]  st1_x_r, st1_len_r;
    logic [VCNT_WIDTH-1:0]  st1_y_r, st1_lcnt_r;
    logic [PIXEL_WIDTH-1:0] st1_dl_r, st1_dr_r;

    logic                   pix_valid_r, pix_sof_r, line_end_r, frame_end_r;
    logic                   err_hlen_r, err_vlen_r;
    logic [HCNT_WIDTH-1:0]  pix_x_r, line_len_r;
    logic [VCNT_WIDTH-1:0]  pix_y_r, line_cnt_r;
    logic [PIXEL_WIDTH-1:0] pix_dl_r, pix_dr_r;
    logic [15:0]            frame_cnt_r;

    assign fval_rise_s =  s1_fval_r & ~s2_fval_r;
    assign fval_fall_s = ~s1_fval_r &  s2_fval_r;
    assign lval_rise_s =  s1_lval_r & ~s2_lval_r;
    assign lval_fall_s = ~s1_lval_r &  s2_lval_r;

    // Input sampling stage (s1) and one-cycle delayed copy (s2) for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_r  <= 1'b0;
            s1_en_r   <= 1'b0;
            s1_fval_r <= 1'b0;
            s1_lval_r <= 1'b0;
            s1_dval_r <= 1'b0;
            s1_clr_r  <= 1'b0;
            s1_dl_r   <= {PIXEL_WIDTH{1'b0}};
            s1_dr_r   <= {PIXEL_WIDTH{1'b0}};
            s2_fval_r <= 1'b0;
            s2_lval_r <= 1'b0;
        end else begin
            s1_vld_r  <= 1'b1;
            s1_en_r   <= bus.enable;
            s1_fval_r <= bus.fval;
            s1_lval_r <= bus.lval;
            s1_dval_r <= bus.dval;
            s1_clr_r  <= bus.err_clr;
            s1_dl_r   <= bus.data_l;
            s1_dr_r   <= bus.data_r;
            s2_fval_r <= s1_fval_r;
            s2_lval_r <= s1_lval_r;
        end
    end

    // Frame state machine, pixel qualification and line/frame bookkeeping
    always_comb begin
        state_nxt_s    = state_r;
        x_nxt_s        = x_cnt_r;
        y_nxt_s        = y_cnt_r;
        has_pix_nxt_s  = has_pix_r;
        sof_done_nxt_s = sof_done_r;
        capture_s      = 1'b0;
        x_base_s       = x_cnt_r;
        y_line_s       = y_cnt_r;
        pix_s          = 1'b0;
        pix_ok_s       = 1'b0;
        sof_s          = 1'b0;
        le_s           = 1'b0;
        herr_s         = 1'b0;
        fe_s           = 1'b0;
        verr_s         = 1'b0;
        case (state_r)
            // s1_vld_r guards against the reset value of s1 posing as FVAL=0
            ST_SYNC: begin
                if (s1_vld_r && !s1_fval_r) state_nxt_s = ST_IDLE;
                else                        state_nxt_s = ST_SYNC;
            end
            ST_IDLE: begin
                if (fval_rise_s && s1_en_r) begin
                    state_nxt_s = ST_FRAME;
                    capture_s   = 1'b1;
                end else if (fval_rise_s) begin
                    state_nxt_s = ST_SKIP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SKIP: begin
                if (fval_fall_s) state_nxt_s = ST_IDLE;
                else             state_nxt_s = ST_SKIP;
            end
            ST_FRAME: begin
                capture_s = 1'b1;
                if (fval_fall_s) state_nxt_s = ST_IDLE;
                else             state_nxt_s = ST_FRAME;
            end
            default: state_nxt_s = ST_SYNC;
        endcase

        if (capture_s) begin
            x_base_s = lval_rise_s ? {HCNT_WIDTH{1'b0}} : x_cnt_r;
            pix_s    = s1_fval_r & s1_lval_r & s1_dval_r;
            x_nxt_s  = x_base_s;
            if (pix_s) begin
                pix_ok_s       = (x_base_s < HACT_C) && (y_cnt_r < VACT_C);
                sof_s          = ~sof_done_r;
                sof_done_nxt_s = 1'b1;
                has_pix_nxt_s  = 1'b1;
                x_nxt_s        = (x_base_s == X_MAX) ? X_MAX : x_base_s + X_ONE;
            end else if (lval_fall_s && has_pix_r) begin
                le_s          = 1'b1;
                herr_s        = (x_cnt_r != HACT_C);
                has_pix_nxt_s = 1'b0;
                y_line_s      = (y_cnt_r == Y_MAX) ? Y_MAX : y_cnt_r + Y_ONE;
            end else begin
                le_s = 1'b0;
            end
            y_nxt_s = y_line_s;
            // The line end above is folded into y_line_s, so a coincident fall counts it
            if (fval_fall_s && (state_r == ST_FRAME)) begin
                fe_s           = 1'b1;
                verr_s         = (y_line_s != VACT_C);
                x_nxt_s        = {HCNT_WIDTH{1'b0}};
                y_nxt_s        = {VCNT_WIDTH{1'b0}};
                has_pix_nxt_s  = 1'b0;
                sof_done_nxt_s = 1'b0;
            end else begin
                fe_s = 1'b0;
            end
        end else begin
            pix_s = 1'b0;
        end
    end

    // State and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_SYNC;
            x_cnt_r    <= {HCNT_WIDTH{1'b0}};
            y_cnt_r    <= {VCNT_WIDTH{1'b0}};
            has_pix_r  <= 1'b0;
            sof_done_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            x_cnt_r    <= x_nxt_s;
            y_cnt_r    <= y_nxt_s;
            has_pix_r  <= has_pix_nxt_s;
            sof_done_r <= sof_done_nxt_s;
        end
    end

    // Event stage: captures the qualified pixel and line/frame results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st1_valid_r <= 1'b0;
            st1_sof_r   <= 1'b0;
            st1_x_r     <= {HCNT_WIDTH{1'b0}};
            st1_y_r     <= {VCNT_WIDTH{1'b0}};
            st1_dl_r    <= {PIXEL_WIDTH{1'b0}};
            st1_dr_r    <= {PIXEL_WIDTH{1'b0}};
            st1_le_r    <= 1'b0;
            st1_len_r   <= {HCNT_WIDTH{1'b0}};
            st1_herr_r  <= 1'b0;
            st1_fe_r    <= 1'b0;
            st1_lcnt_r  <= {VCNT_WIDTH{1'b0}};
            st1_verr_r  <= 1'b0;
            st1_clr_r   <= 1'b0;
        end else begin
            st1_valid_r <= pix_ok_s;
            st1_sof_r   <= sof_s & pix_ok_s;
            if (pix_ok_s) begin
                st1_x_r  <= x_base_s;
                st1_y_r  <= y_cnt_r;
                st1_dl_r <= s1_dl_r;
                st1_dr_r <= s1_dr_r;
            end else begin
                st1_x_r  <= st1_x_r;
                st1_y_r  <= st1_y_r;
                st1_dl_r <= st1_dl_r;
                st1_dr_r <= st1_dr_r;
            end
            st1_le_r   <= le_s;
            st1_len_r  <= le_s ? x_cnt_r : st1_len_r;
            st1_herr_r <= le_s & herr_s;
            st1_fe_r   <= fe_s;
            st1_lcnt_r <= fe_s ? y_line_s : st1_lcnt_r;
            st1_verr_r <= fe_s & verr_s;
            st1_clr_r  <= s1_clr_r;
        end
    end

    // Output registers; error flags are sticky and a new error beats a clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_valid_r <= 1'b0;
            pix_sof_r   <= 1'b0;
            pix_x_r     <= {HCNT_WIDTH{1'b0}};
            pix_y_r     <= {VCNT_WIDTH{1'b0}};
            pix_dl_r    <= {PIXEL_WIDTH{1'b0}};
            pix_dr_r    <= {PIXEL_WIDTH{1'b0}};
            line_end_r  <= 1'b0;
            frame_end_r <= 1'b0;
            line_len_r  <= {HCNT_WIDTH{1'b0}};
            line_cnt_r  <= {VCNT_WIDTH{1'b0}};
            frame_cnt_r <= 16'd0;
            err_hlen_r  <= 1'b0;
            err_vlen_r  <= 1'b0;
        end else begin
            pix_valid_r <= st1_valid_r;
            pix_sof_r   <= st1_sof_r;
            if (st1_valid_r) begin
                pix_x_r  <= st1_x_r;
                pix_y_r  <= st1_y_r;
                pix_dl_r <= st1_dl_r;
                pix_dr_r <= st1_dr_r;
            end else begin
                pix_x_r  <= pix_x_r;
                pix_y_r  <= pix_y_r;
                pix_dl_r <= pix_dl_r;
                pix_dr_r <= pix_dr_r;
            end
            line_end_r  <= st1_le_r;
            frame_end_r <= st1_fe_r;
            line_len_r  <= st1_le_r ? st1_len_r : line_len_r;
            line_cnt_r  <= st1_fe_r ? st1_lcnt_r : line_cnt_r;
            frame_cnt_r <= st1_fe_r ? frame_cnt_r + 16'd1 : frame_cnt_r;
            err_hlen_r  <= st1_herr_r | (err_hlen_r & ~st1_clr_r);
            err_vlen_r  <= st1_verr_r | (err_vlen_r & ~st1_clr_r);
        end
    end

    assign bus.pix_valid  = pix_valid_r;
    assign bus.pix_sof    = pix_sof_r;
    assign bus.pix_x      = pix_x_r;
    assign bus.pix_y      = pix_y_r;
    assign bus.pix_data_l = pix_dl_r;
    assign bus.pix_data_r = pix_dr_r;
    assign bus.line_end   = line_end_r;
    assign bus.frame_end  = frame_end_r;
    assign bus.line_len   = line_len_r;
    assign bus.line_cnt   = line_cnt_r;
    assign bus.frame_cnt  = frame_cnt_r;
    assign bus.err_hlen   = err_hlen_r;
    assign bus.err_vlen   = err_vlen_r;
endmodule

// File: tb/tb_cam_rx_capture.sv
// Directed bench for cam_rx_capture using a reduced 8x6 active geometry;
// expected pixels are queued by the driver and compared by a negedge monitor.
module tb_cam_rx_capture;
    localparam int PW   = 8;
    localparam int HW   = 10;
    localparam int VW   = 9;
    localparam int HACT = 8;
    localparam int VACT = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cam_rx_capture_if #(.PIXEL_WIDTH(PW), .HCNT_WIDTH(HW), .VCNT_WIDTH(VW)) bus ();

    cam_rx_capture #(
        .PIXEL_WIDTH(PW), .HCNT_WIDTH(HW), .VCNT_WIDTH(VW), .HACT(HACT), .VACT(VACT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    int          edge_cnt = 0;
    logic [35:0] exp_pix_q[$];
    int          exp_stamp_q[$];
    int          fe_stamp = -1;
    int          pix_cnt, sof_cnt, le_cnt, fe_cnt, coinc_cnt;
    int          y_exp;
    int          dnum = 0;
    bit          first_exp;
    bit          cap;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Monitor: every valid pixel must match the head of the expected queue, 3 edges after driving
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.pix_valid) begin
                pix_cnt++;
                if (bus.pix_sof) sof_cnt++;
                if (exp_pix_q.size() == 0) begin
                    check("unexpected_pix", 64'd1, 64'd0);
                end else begin
                    check("pix", 64'({bus.pix_sof, bus.pix_x, bus.pix_y, bus.pix_data_l, bus.pix_data_r}),
                          64'(exp_pix_q.pop_front()));
                    check("pix_latency", 64'(edge_cnt), 64'(exp_stamp_q.pop_front()));
                end
            end
            if (bus.line_end) le_cnt++;
            if (bus.frame_end) begin
                fe_cnt++;
                check("fe_latency", 64'(edge_cnt), 64'(fe_stamp));
                if (bus.line_end) coinc_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        pix_cnt = 0; sof_cnt = 0; le_cnt = 0; fe_cnt = 0; coinc_cnt = 0;
    endtask

    task automatic drive_line(input int npix, input bit dv, input bit fall_fval);
        logic [7:0] dl, dr;
        bus.lval = 1'b1;
        for (int i = 0; i < npix; i++) begin
            dr = 8'(dnum);
            dl = 8'(dnum * 7 + 3);
            bus.dval   = dv;
            bus.data_l = dl;
            bus.data_r = dr;
            if (cap && dv) begin
                if (i < HACT && y_exp < VACT) begin
                    exp_pix_q.push_back({first_exp, 10'(i), 9'(y_exp), dl, dr});
                    exp_stamp_q.push_back(edge_cnt + 3);
                end
                first_exp = 1'b0;
            end
            dnum++;
            tick();
        end
        bus.lval = 1'b0;
        bus.dval = 1'b0;
        if (fall_fval) begin
            bus.fval = 1'b0;
            fe_stamp = edge_cnt + 3;
        end
        if (dv && npix > 0) y_exp++;
        tick();
        tick();
    endtask

    task automatic drive_frame(input int nlines, input int long_at, input int empty_at,
                               input int en_drop_at, input bit coinc, input bit capture);
        cap = capture; first_exp = 1'b1; y_exp = 0;
        bus.fval = 1'b1;
        tick();
        tick();
        for (int l = 0; l < nlines; l++) begin
            if (l == en_drop_at) bus.enable = 1'b0;
            if (l == empty_at) drive_line(4, 1'b0, 1'b0);
            drive_line((l == long_at) ? HACT + 1 : HACT, 1'b1, coinc && (l == nlines - 1));
        end
        if (!coinc) begin
            bus.fval = 1'b0;
            fe_stamp = edge_cnt + 3;
            tick();
        end
        repeat (4) tick();
    endtask

    task automatic pulse_err_clr();
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.enable = 1'b1; bus.fval = 1'b0; bus.lval = 1'b0; bus.dval = 1'b0;
        bus.data_l = 8'd0; bus.data_r = 8'd0; bus.err_clr = 1'b0;
        clear_counts();
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();

        check("rst_pix_valid", 64'(bus.pix_valid), 64'd0);
        check("rst_frame_cnt", 64'(bus.frame_cnt), 64'd0);
        check("rst_line_len",  64'(bus.line_len), 64'd0);
        check("rst_line_cnt",  64'(bus.line_cnt), 64'd0);
        check("rst_errs",      64'({bus.err_hlen, bus.err_vlen}), 64'd0);
        check("rst_pix_xy",    64'({bus.pix_x, bus.pix_y}), 64'd0);

        // Nominal: three full frames
        for (int k = 1; k <= 3; k++) begin
            clear_counts();
            drive_frame(VACT, -1, -1, -1, 1'b0, 1'b1);
            check("nom_pix_cnt",   64'(pix_cnt), 64'(HACT * VACT));
            check("nom_sof_cnt",   64'(sof_cnt), 64'd1);
            check("nom_le_cnt",    64'(le_cnt), 64'(VACT));
            check("nom_fe_cnt",    64'(fe_cnt), 64'd1);
            check("nom_line_len",  64'(bus.line_len), 64'(HACT));
            check("nom_line_cnt",  64'(bus.line_cnt), 64'(VACT));
            check("nom_frame_cnt", 64'(bus.frame_cnt), 64'(k));
            check("nom_last_xy",   64'({bus.pix_x, bus.pix_y}), 64'({10'(HACT - 1), 9'(VACT - 1)}));
            check("nom_errs",      64'({bus.err_hlen, bus.err_vlen}), 64'd0);
        end

        // LVAL and FVAL fall together
        clear_counts();
        drive_frame(VACT, -1, -1, -1, 1'b1, 1'b1);
        check("coinc_same_cycle", 64'(coinc_cnt), 64'd1);
        check("coinc_le_cnt",     64'(le_cnt), 64'(VACT));
        check("coinc_line_cnt",   64'(bus.line_cnt), 64'(VACT));
        check("coinc_frame_cnt",  64'(bus.frame_cnt), 64'd4);
        check("coinc_errs",       64'({bus.err_hlen, bus.err_vlen}), 64'd0);

        // Oversize final line: X=HACT dropped, length still measured
        clear_counts();
        drive_frame(VACT, VACT - 1, -1, -1, 1'b0, 1'b1);
        check("long_pix_cnt",  64'(pix_cnt), 64'(HACT * VACT));
        check("long_line_len", 64'(bus.line_len), 64'(HACT + 1));
        check("long_err_hlen", 64'(bus.err_hlen), 64'd1);
        check("long_err_vlen", 64'(bus.err_vlen), 64'd0);
        clear_counts();
        drive_frame(VACT, -1, -1, -1, 1'b0, 1'b1);
        check("long_sticky",   64'(bus.err_hlen), 64'd1);
        check("long_frame_cnt", 64'(bus.frame_cnt), 64'd6);
        pulse_err_clr();
        check("long_cleared",  64'(bus.err_hlen), 64'd0);

        // Short frame with an empty line that must not count
        clear_counts();
        drive_frame(VACT - 1, -1, 2, -1, 1'b0, 1'b1);
        check("short_fe_cnt",    64'(fe_cnt), 64'd1);
        check("short_le_cnt",    64'(le_cnt), 64'(VACT - 1));
        check("short_pix_cnt",   64'(pix_cnt), 64'(HACT * (VACT - 1)));
        check("short_line_cnt",  64'(bus.line_cnt), 64'(VACT - 1));
        check("short_err_vlen",  64'(bus.err_vlen), 64'd1);
        check("short_err_hlen",  64'(bus.err_hlen), 64'd0);
        pulse_err_clr();
        check("short_cleared",   64'(bus.err_vlen), 64'd0);

        // ENABLE dropped mid-frame, then held low at the next frame start
        clear_counts();
        drive_frame(VACT, -1, -1, 2, 1'b0, 1'b1);
        check("en1_pix_cnt",   64'(pix_cnt), 64'(HACT * VACT));
        check("en1_fe_cnt",    64'(fe_cnt), 64'd1);
        check("en1_frame_cnt", 64'(bus.frame_cnt), 64'd8);
        clear_counts();
        drive_frame(VACT, -1, -1, -1, 1'b0, 1'b0);
        check("en2_pix_cnt",   64'(pix_cnt), 64'd0);
        check("en2_fe_cnt",    64'(fe_cnt), 64'd0);
        check("en2_le_cnt",    64'(le_cnt), 64'd0);
        check("en2_frame_cnt", 64'(bus.frame_cnt), 64'd8);
        bus.enable = 1'b1;

        // Reset in the middle of a captured frame, FVAL still high at release
        clear_counts();
        cap = 1'b1; first_exp = 1'b1; y_exp = 0;
        bus.fval = 1'b1;
        tick();
        tick();
        drive_line(HACT, 1'b1, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        cap = 1'b0;
        clear_counts();
        drive_line(HACT, 1'b1, 1'b0);
        drive_line(HACT, 1'b1, 1'b0);
        bus.fval = 1'b0;
        repeat (5) tick();
        check("rstmid_pix_cnt",   64'(pix_cnt), 64'd0);
        check("rstmid_fe_cnt",    64'(fe_cnt), 64'd0);
        check("rstmid_frame_cnt", 64'(bus.frame_cnt), 64'd0);
        check("rstmid_line_cnt",  64'(bus.line_cnt), 64'd0);
        clear_counts();
        drive_frame(VACT, -1, -1, -1, 1'b0, 1'b1);
        check("rstmid_full_pix",   64'(pix_cnt), 64'(HACT * VACT));
        check("rstmid_full_sof",   64'(sof_cnt), 64'd1);
        check("rstmid_full_fcnt",  64'(bus.frame_cnt), 64'd1);
        check("rstmid_full_lcnt",  64'(bus.line_cnt), 64'(VACT));

        check("queue_drained", 64'(exp_pix_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
